// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU op codes used by the control unit and
// the execute-stage blocks that decode them.
package riscv_pkg;

    localparam logic [3:0] ALUOP_MUL   = 4'b0101;
    localparam logic [3:0] ALUOP_MULH  = 4'b0110;
    localparam logic [3:0] ALUOP_MULHU = 4'b0111;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALUOP_MUL) || (op == ALUOP_MULH) || (op == ALUOP_MULHU);
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for mul/mulh/mulhu: stalls the core for
// WIDTH iterations, then presents the selected product half for one cycle.
module mul_sequencer
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int              CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;

    logic [3:0]         r_op;
    logic               r_neg;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic               w_is_mulh;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc_sum;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_result_half;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        stall        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && is_mul_op(aluop)) begin
                    w_accept     = 1'b1;
                    stall        = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            // The retiring instruction still shows start here; never re-accept.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // mulh runs on magnitudes and fixes the sign at the end; the most negative
    // value negates to itself, which is its correct unsigned magnitude.
    assign w_is_mulh = (aluop == ALUOP_MULH);
    assign w_a_mag   = (w_is_mulh && a[WIDTH-1]) ? -a : a;
    assign w_b_mag   = (w_is_mulh && b[WIDTH-1]) ? -b : b;

    assign w_last        = (r_cnt == LAST_ITER);
    assign w_acc_sum     = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_product     = r_neg ? -w_acc_sum : w_acc_sum;
    assign w_result_half = (r_op == ALUOP_MUL) ? w_product[WIDTH-1:0]
                                               : w_product[2*WIDTH-1:WIDTH];

    // NOTE: the operand registers only matter after an accept, but they are
    // cleared on reset too so the post-reset state is fully deterministic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_op     <= aluop;
                r_neg    <= w_is_mulh && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_acc    <= w_acc_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_result_half;
                end
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
